stepper_step_gen: RTL

Downstream consumer of the 16-bit UART command word. Converts each received command (direction bit plus 15-bit half-period) into a step pulse train and H-bridge direction pins. Sequences direction changes with a setup interval and optionally stops after a fixed step budget. Sits between the UART receiver's assembled word output and the motor driver pins.

---
 rtl/stepper_step_gen.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/stepper_step_gen.sv
// Stepper step generator: turns 16-bit {dir, rate} commands into a 50% duty step
// train plus H-bridge direction pins. Optional step budget under `STEP_LIMIT_EN`.
module stepper_step_gen #(
  parameter int CLKS_PER_TICK = 100,
  parameter int DIR_SETUP     = 50,
  parameter int MAX_STEPS     = 1600
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic [15:0] i_Cmd_Word,
  input  logic        i_Cmd_DV,
  output logic        o_Step,
  output logic        o_Dir_A,
  output logic        o_Dir_B,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [15:0] o_Step_Count
);

  // Half-period register holds the full 15-bit rate x CLKS_PER_TICK product.
  localparam int HW = 15 + $clog2(CLKS_PER_TICK + 1);
  localparam int SW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

  localparam logic [HW-1:0] CPT        = HW'(CLKS_PER_TICK);
  localparam logic [HW-1:0] ONE_H      = HW'(1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(DIR_SETUP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
`ifdef STEP_LIMIT_EN
  localparam logic [1:0] S_DONE  = 2'd3;
`endif

  logic [1:0]    state_q, state_d;
  logic          dir_q, dir_d;
  logic [14:0]   rate_q, rate_d;
  logic          pend_q, pend_d;
  logic          pin_a_q, pin_a_d;
  logic          pin_b_q, pin_b_d;
  logic          step_q, step_d;
  logic [HW-1:0] half_q, half_d;
  logic [HW-1:0] phase_q, phase_d;
  logic [SW-1:0] setup_q, setup_d;
  logic [15:0]   count_q, count_d;

  logic [HW-1:0] h_next;
  logic          phase_last;
  logic          stop_req;
  logic          rev_req;
  logic          limit_hit;

  assign h_next     = HW'(rate_q) * CPT;
  assign phase_last = (phase_q == (half_q - ONE_H));
  assign stop_req   = (rate_q == 15'd0);
  // Pin A mirrors the direction bit, so a mismatch means a reversal is pending.
  assign rev_req    = (dir_q != pin_a_q);

`ifdef STEP_LIMIT_EN
  assign limit_hit = (count_q == 16'(MAX_STEPS));
`else
  logic max_steps_unused;
  assign limit_hit        = 1'b0;
  assign max_steps_unused = (MAX_STEPS != 0);
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rate_d  = rate_q;
    pend_d  = i_Cmd_DV;
    pin_a_d = pin_a_q;
    pin_b_d = pin_b_q;
    step_d  = step_q;
    half_d  = half_q;
    phase_d = phase_q;
    setup_d = setup_q;
    count_d = count_q;

    if (i_Cmd_DV) begin
      dir_d  = i_Cmd_Word[15];
      rate_d = i_Cmd_Word[14:0];
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q && !stop_req) begin
          state_d = S_SETUP;
          pin_a_d = dir_q;
          pin_b_d = !dir_q;
          count_d = 16'd0;
          setup_d = '0;
          step_d  = 1'b0;
        end
      end

      S_SETUP: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (rev_req) begin
          pin_a_d = dir_q;
          pin_b_d = !dir_q;
          count_d = 16'd0;
          setup_d = '0;
        end else if (setup_q == SETUP_LAST) begin
          state_d = S_RUN;
          step_d  = 1'b1;
          count_d = count_q + 16'd1;
          phase_d = '0;
          half_d  = h_next;
        end else begin
          setup_d = setup_q + SW'(1);
        end
      end

      S_RUN: begin
        // A low phase may be abandoned at once; a high phase always runs to its end.
        if (!step_q && (stop_req || rev_req)) begin
          if (stop_req) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SETUP;
            pin_a_d = dir_q;
            pin_b_d = !dir_q;
            count_d = 16'd0;
            setup_d = '0;
          end
        end else if (phase_last) begin
          phase_d = '0;
          half_d  = h_next;
          if (step_q) begin
            step_d = 1'b0;
            if (stop_req) begin
              state_d = S_IDLE;
            end else if (rev_req) begin
              state_d = S_SETUP;
              pin_a_d = dir_q;
              pin_b_d = !dir_q;
              count_d = 16'd0;
              setup_d = '0;
            end else if (limit_hit) begin
`ifdef STEP_LIMIT_EN
              state_d = S_DONE;
`endif
            end
          end else begin
            step_d  = 1'b1;
            count_d = count_q + 16'd1;
          end
        end else begin
          phase_d = phase_q + ONE_H;
        end
      end

      default: begin
        state_d = S_IDLE;
        step_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      rate_q  <= 15'd0;
      pend_q  <= 1'b0;
      pin_a_q <= 1'b0;
      pin_b_q <= 1'b0;
      step_q  <= 1'b0;
      half_q  <= '0;
      phase_q <= '0;
      setup_q <= '0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rate_q  <= rate_d;
      pend_q  <= pend_d;
      pin_a_q <= pin_a_d;
      pin_b_q <= pin_b_d;
      step_q  <= step_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      setup_q <= setup_d;
      count_q <= count_d;
    end
  end

  assign o_Step       = step_q;
  assign o_Dir_A      = pin_a_q;
  assign o_Dir_B      = pin_b_q;
  assign o_Busy       = (state_q == S_SETUP) || (state_q == S_RUN);
  assign o_Step_Count = count_q;
`ifdef STEP_LIMIT_EN
  assign o_Done       = (state_q == S_DONE);
`else
  assign o_Done       = 1'b0;
`endif

endmodule
